// File: rtl/dft_bin_synthesizer.sv
// ---------------------------------------------------------------------------
// dft_bin_synthesizer
//   Synthesizes the time-domain tone x[n] = C * W[n], n = 0..len, from one
//   complex bin coefficient C per frame and a runtime-writable twiddle table.
//   It is the inverse of the single-bin DFT correlator and uses the same
//   twiddle word format ({im[63:32], re[31:0]}, low TWIDD_WIDTH bits of each
//   half) and the same frame length control (delay_line = length - 1).
//
//   Coefficients are double-buffered: the first one after reset goes straight
//   to the active register; later ones wait in a shadow register and take
//   effect at the next frame wrap. With no new coefficient the tone repeats.
//
//   The table has no power-up contents; load it through the write port.
//
//   Pipeline (4 clk, sample_en -> dout_valid):
//     S1 address/coefficient register, S2 table read, S3 complex multiply,
//     S4 truncate + saturate to DOUT_WIDTH/DOUT_POINT.
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active low
//   delay_line    frame length - 1, latched at start and at every wrap,
//                 clamped to DFT_LEN-1
//   coeff_re/im   bin coefficient (signed, DIN_POINT fraction bits)
//   coeff_valid   coefficient offered
//   coeff_ready   shadow register empty; accepted when valid & ready
//   sample_en     emit one output sample this cycle
//   twidd_we      twiddle table write strobe
//   twidd_waddr   twiddle table write address
//   twidd_wdata   twiddle table write data {im, re}
//   dout_re/im    synthesized sample (signed, DOUT_POINT fraction bits)
//   dout_valid    sample valid
//   frame_start   high with sample n = 0
//   cast_warning  this sample saturated on re or im
// ---------------------------------------------------------------------------
module dft_bin_synthesizer #(
  parameter int DIN_WIDTH   = 16,
  parameter int DIN_POINT   = 15,
  parameter int TWIDD_WIDTH = 16,
  parameter int TWIDD_POINT = 14,
  parameter int DFT_LEN     = 128,
  parameter int DOUT_WIDTH  = 16,
  parameter int DOUT_POINT  = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  delay_line,
  input  logic signed [DIN_WIDTH-1:0]  coeff_re,
  input  logic signed [DIN_WIDTH-1:0]  coeff_im,
  input  logic                         coeff_valid,
  output logic                         coeff_ready,
  input  logic                         sample_en,
  input  logic                         twidd_we,
  input  logic [$clog2(DFT_LEN)-1:0]   twidd_waddr,
  input  logic [63:0]                  twidd_wdata,
  output logic signed [DOUT_WIDTH-1:0] dout_re,
  output logic signed [DOUT_WIDTH-1:0] dout_im,
  output logic                         dout_valid,
  output logic                         frame_start,
  output logic                         cast_warning
);

  localparam int AW    = $clog2(DFT_LEN);
  localparam int PW    = DIN_WIDTH + TWIDD_WIDTH + 1;   // full-precision product width
  localparam int SHIFT = DIN_POINT + TWIDD_POINT - DOUT_POINT;
  localparam logic signed [PW-1:0] SAT_MAX = PW'(2**(DOUT_WIDTH-1) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX;  // symmetric clip
  localparam logic [AW-1:0]        LEN_MAX = AW'(DFT_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic                         sat;
    logic signed [DOUT_WIDTH-1:0] val;
  } cast_t;

  // Truncate fraction bits (floor), then clip to +/-max.
  function automatic cast_t cast_sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] sh;
    cast_t r;
    sh = v >>> SHIFT;
    r.sat = 1'b0;
    r.val = sh[DOUT_WIDTH-1:0];
    if (sh > SAT_MAX) begin
      r.sat = 1'b1;
      r.val = SAT_MAX[DOUT_WIDTH-1:0];
    end else if (sh < SAT_MIN) begin
      r.sat = 1'b1;
      r.val = SAT_MIN[DOUT_WIDTH-1:0];
    end
    return r;
  endfunction

  // Control state
  state_t        state_q, state_d;
  logic [AW-1:0] n_q, len_q, len_in;
  logic          shadow_full;
  logic          accept, start, advance, wrap;

  // Coefficient registers
  logic signed [DIN_WIDTH-1:0] act_re, act_im, sh_re, sh_im;

  // Pipeline
  logic                          s1_valid, s1_fs;
  logic [AW-1:0]                 s1_addr;
  logic signed [DIN_WIDTH-1:0]   s1_c_re, s1_c_im;
  logic                          s2_valid, s2_fs;
  logic [63:0]                   s2_word;
  logic signed [DIN_WIDTH-1:0]   s2_c_re, s2_c_im;
  logic signed [TWIDD_WIDTH-1:0] w_re, w_im;
  logic signed [PW-1:0]          m_re, m_im;
  logic                          s3_valid, s3_fs;
  logic signed [PW-1:0]          s3_re, s3_im;
  cast_t                         c_re, c_im;

  logic [63:0] mem [DFT_LEN];

  assign coeff_ready = !shadow_full;
  assign accept      = coeff_valid && coeff_ready;
  assign len_in      = (delay_line > 32'(DFT_LEN - 1)) ? LEN_MAX : delay_line[AW-1:0];

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    advance = 1'b0;
    wrap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (sample_en) begin
          advance = 1'b1;
          wrap    = (n_q == len_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      len_q        <= '0;
      shadow_full  <= 1'b0;
      s1_valid     <= 1'b0;
      s1_fs        <= 1'b0;
      s2_valid     <= 1'b0;
      s2_fs        <= 1'b0;
      s3_valid     <= 1'b0;
      s3_fs        <= 1'b0;
      dout_re      <= '0;
      dout_im      <= '0;
      dout_valid   <= 1'b0;
      frame_start  <= 1'b0;
      cast_warning <= 1'b0;
    end else begin
      state_q <= state_d;

      if (start) begin
        n_q   <= '0;
        len_q <= len_in;
      end else if (advance) begin
        n_q <= wrap ? '0 : n_q + AW'(1);
        if (wrap) len_q <= len_in;
      end

      // A wrap drains the shadow; a same-cycle accept (only possible when the
      // shadow was already empty) refills it for the following wrap.
      if (wrap) shadow_full <= 1'b0;
      if (accept && state_q == RUN) shadow_full <= 1'b1;

      s1_valid <= advance;
      s1_fs    <= advance && (n_q == '0);
      s2_valid <= s1_valid;
      s2_fs    <= s1_fs;
      s3_valid <= s2_valid;
      s3_fs    <= s2_fs;

      if (s3_valid) begin
        dout_re <= c_re.val;
        dout_im <= c_im.val;
      end
      dout_valid   <= s3_valid;
      frame_start  <= s3_valid && s3_fs;
      cast_warning <= s3_valid && (c_re.sat || c_im.sat);
    end
  end

  // NOTE: datapath and coefficient registers carry no reset; they are only
  // observed when a reset-cleared valid travels with them, and leaving them
  // unreset keeps the table and pipeline mappable to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (start) begin
      act_re <= coeff_re;
      act_im <= coeff_im;
    end else if (wrap && shadow_full) begin
      act_re <= sh_re;
      act_im <= sh_im;
    end
    if (accept && state_q == RUN) begin
      sh_re <= coeff_re;
      sh_im <= coeff_im;
    end

    s1_addr <= n_q;
    s1_c_re <= act_re;
    s1_c_im <= act_im;
    s2_c_re <= s1_c_re;
    s2_c_im <= s1_c_im;
    s3_re   <= m_re;
    s3_im   <= m_im;
  end

  // Table: a read and a write to the same address in one cycle return the
  // old word.
  always_ff @(posedge clk) begin
    if (twidd_we) mem[twidd_waddr] <= twidd_wdata;
    s2_word <= mem[s1_addr];
  end

  assign w_re = s2_word[TWIDD_WIDTH-1:0];
  assign w_im = s2_word[32 +: TWIDD_WIDTH];

  logic unused_twidd;
  assign unused_twidd = ^{s2_word[63:32+TWIDD_WIDTH], s2_word[31:TWIDD_WIDTH]};

  // re = Cr*Wr - Ci*Wi, im = Cr*Wi + Ci*Wr at full precision.
  always_comb begin
    m_re = PW'(s2_c_re) * PW'(w_re) - PW'(s2_c_im) * PW'(w_im);
    m_im = PW'(s2_c_re) * PW'(w_im) + PW'(s2_c_im) * PW'(w_re);
  end

  assign c_re = cast_sat(s3_re);
  assign c_im = cast_sat(s3_im);

endmodule
